// File: rtl/pwm_multi_channel_if.sv
// Bus bundle for pwm_multi_channel.
// master : the config source (software-facing register block or bench).
//          Drives enable/load and the shadow config values, observes outputs.
// slave  : the PWM generator itself.
// Signals:
//   enable, load, center_mode, period, prescale, duty, polarity  (master -> slave)
//   pwm_out, period_start, load_ack                              (slave -> master)
interface pwm_multi_channel_if #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 8
);
  logic                      enable;
  logic                      load;
  logic                      center_mode;
  logic [CNT_W-1:0]          period;
  logic [PRESC_W-1:0]        prescale;
  logic [NUM_CH*CNT_W-1:0]   duty;
  logic [NUM_CH-1:0]         polarity;
  logic [NUM_CH-1:0]         pwm_out;
  logic                      period_start;
  logic                      load_ack;

  modport master (
    output enable, load, center_mode, period, prescale, duty, polarity,
    input  pwm_out, period_start, load_ack
  );

  modport slave (
    input  enable, load, center_mode, period, prescale, duty, polarity,
    output pwm_out, period_start, load_ack
  );
endinterface

// File: rtl/pwm_multi_channel.sv
// N-channel PWM generator sharing one prescaled timebase.
// Edge-aligned (0..TOP) or centre-aligned (0..TOP..1) counting, per-channel
// polarity, and double-buffered config: a load pulse fills the shadow set,
// which is copied to the active set only at a period boundary (or at once
// while the timebase is disabled), acknowledged by a one-clock load_ack.
// Ports:
//   clk  - clock, all logic on posedge
//   rst  - asynchronous active-high reset
//   bus  - pwm_multi_channel_if.slave: config inputs, pwm_out,
//          period_start and load_ack outputs (all outputs registered)
module pwm_multi_channel #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  pwm_multi_channel_if.slave bus
);

  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

  function automatic logic [NUM_CH-1:0] compare_duty(
    input logic [CNT_W-1:0]        cnt,
    input logic [NUM_CH*CNT_W-1:0] duty
  );
    logic [NUM_CH-1:0] raw;
    raw = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      raw[i] = (cnt < duty[i*CNT_W +: CNT_W]);
    end
    return raw;
  endfunction

  logic [PRESC_W-1:0]      presc_cnt_q, presc_cnt_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    dir_down_q, dir_down_d;
  logic                    pending_q, pending_d;

  logic [NUM_CH*CNT_W-1:0] sh_duty_q, sh_duty_d, act_duty_q, act_duty_d;
  logic [CNT_W-1:0]        sh_period_q, sh_period_d, act_period_q, act_period_d;
  logic [PRESC_W-1:0]      sh_presc_q, sh_presc_d, act_presc_q, act_presc_d;
  logic                    sh_center_q, sh_center_d, act_center_q, act_center_d;
  logic [NUM_CH-1:0]       sh_pol_q, sh_pol_d, act_pol_q, act_pol_d;

  logic [NUM_CH-1:0]       pwm_out_q, pwm_out_d;
  logic                    period_start_q, period_start_d;
  logic                    load_ack_q, load_ack_d;

  logic tick, centre, going_down, boundary, xfer;

  assign tick       = (presc_cnt_q == act_presc_q);
  // TOP=0 in centre mode degenerates to edge counting.
  assign centre     = act_center_q && (act_period_q != '0);
  // In centre mode the step taken from TOP is already downward.
  assign going_down = dir_down_q || (cnt_q == act_period_q);
  assign boundary   = centre ? (going_down && (cnt_q == CNT_ONE))
                             : (cnt_q == act_period_q);
  // A load in the same clock as the boundary is applied at that boundary.
  assign xfer       = (pending_q || bus.load) && (!bus.enable || (tick && boundary));

  always_comb begin
    presc_cnt_d    = presc_cnt_q;
    cnt_d          = cnt_q;
    dir_down_d     = dir_down_q;
    pending_d      = pending_q;
    sh_duty_d      = sh_duty_q;
    sh_period_d    = sh_period_q;
    sh_presc_d     = sh_presc_q;
    sh_center_d    = sh_center_q;
    sh_pol_d       = sh_pol_q;
    act_duty_d     = act_duty_q;
    act_period_d   = act_period_q;
    act_presc_d    = act_presc_q;
    act_center_d   = act_center_q;
    act_pol_d      = act_pol_q;
    pwm_out_d      = pwm_out_q;
    period_start_d = 1'b0;
    load_ack_d     = xfer;

    if (bus.load) begin
      sh_duty_d   = bus.duty;
      sh_period_d = bus.period;
      sh_presc_d  = bus.prescale;
      sh_center_d = bus.center_mode;
      sh_pol_d    = bus.polarity;
    end

    if (xfer) begin
      act_duty_d   = sh_duty_d;
      act_period_d = sh_period_d;
      act_presc_d  = sh_presc_d;
      act_center_d = sh_center_d;
      act_pol_d    = sh_pol_d;
      pending_d    = 1'b0;
    end else begin
      pending_d    = pending_q | bus.load;
    end

    if (!bus.enable) begin
      presc_cnt_d = '0;
      cnt_d       = '0;
      dir_down_d  = 1'b0;
      pwm_out_d   = act_pol_q;
    end else begin
      pwm_out_d      = compare_duty(cnt_q, act_duty_q) ^ act_pol_q;
      // cnt=0 with a fresh prescaler is the first clock of a period.
      period_start_d = (cnt_q == '0) && (presc_cnt_q == '0);
      if (tick) begin
        presc_cnt_d = '0;
        if (boundary) begin
          cnt_d      = '0;
          dir_down_d = 1'b0;
        end else if (centre && going_down) begin
          cnt_d      = cnt_q - CNT_ONE;
          dir_down_d = 1'b1;
        end else begin
          cnt_d      = cnt_q + CNT_ONE;
          dir_down_d = 1'b0;
        end
      end else begin
        presc_cnt_d = presc_cnt_q + PRESC_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt_q    <= '0;
      cnt_q          <= '0;
      dir_down_q     <= 1'b0;
      pending_q      <= 1'b0;
      sh_duty_q      <= '0;
      sh_period_q    <= '1;
      sh_presc_q     <= '0;
      sh_center_q    <= 1'b0;
      sh_pol_q       <= '0;
      act_duty_q     <= '0;
      act_period_q   <= '1;
      act_presc_q    <= '0;
      act_center_q   <= 1'b0;
      act_pol_q      <= '0;
      pwm_out_q      <= '0;
      period_start_q <= 1'b0;
      load_ack_q     <= 1'b0;
    end else begin
      presc_cnt_q    <= presc_cnt_d;
      cnt_q          <= cnt_d;
      dir_down_q     <= dir_down_d;
      pending_q      <= pending_d;
      sh_duty_q      <= sh_duty_d;
      sh_period_q    <= sh_period_d;
      sh_presc_q     <= sh_presc_d;
      sh_center_q    <= sh_center_d;
      sh_pol_q       <= sh_pol_d;
      act_duty_q     <= act_duty_d;
      act_period_q   <= act_period_d;
      act_presc_q    <= act_presc_d;
      act_center_q   <= act_center_d;
      act_pol_q      <= act_pol_d;
      pwm_out_q      <= pwm_out_d;
      period_start_q <= period_start_d;
      load_ack_q     <= load_ack_d;
    end
  end

  assign bus.pwm_out      = pwm_out_q;
  assign bus.period_start = period_start_q;
  assign bus.load_ack     = load_ack_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Bench for pwm_multi_channel: a period-position model predicts every output
// each clock; directed scenarios add hand-computed high-time counts.
module tb_pwm_multi_channel;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pwm_multi_channel_if #(.NUM_CH(4), .CNT_W(8), .PRESC_W(8)) pif ();

  pwm_multi_channel #(.NUM_CH(4), .CNT_W(8), .PRESC_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (pif)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- model: tracks position inside the current period
  logic [7:0] a_top, s_top, a_presc, s_presc;
  logic       a_mode, s_mode, m_pend;
  logic [7:0] a_duty[4];
  logic [7:0] s_duty[4];
  logic [3:0] a_pol, s_pol;
  int         pos, sub;
  logic [3:0] e_pwm;
  logic       e_ps, e_ack;

  initial forever begin : model
    int len, cnt;
    bit tck, eop, pend_eff, xf;
    @(posedge clk or posedge rst);
    if (rst) begin
      a_top = 8'hFF; s_top = 8'hFF; a_presc = 0; s_presc = 0;
      a_mode = 0; s_mode = 0; a_pol = 0; s_pol = 0; m_pend = 0;
      for (int i = 0; i < 4; i++) begin a_duty[i] = 0; s_duty[i] = 0; end
      pos = 0; sub = 0; e_pwm = 0; e_ps = 0; e_ack = 0;
    end else begin
      len = (a_mode && a_top != 0) ? 2 * int'(a_top) : int'(a_top) + 1;
      cnt = (a_mode && a_top != 0 && pos > int'(a_top)) ? 2 * int'(a_top) - pos : pos;
      if (pif.enable) begin
        for (int i = 0; i < 4; i++) e_pwm[i] = (cnt < int'(a_duty[i])) ^ a_pol[i];
        e_ps = (pos == 0 && sub == 0);
      end else begin
        e_pwm = a_pol;
        e_ps  = 0;
      end
      if (pif.load) begin
        s_top = pif.period; s_presc = pif.prescale; s_mode = pif.center_mode;
        s_pol = pif.polarity;
        for (int i = 0; i < 4; i++) s_duty[i] = pif.duty[i*8 +: 8];
      end
      tck      = pif.enable && (sub == int'(a_presc));
      eop      = tck && (pos == len - 1);
      pend_eff = m_pend || pif.load;
      xf       = pend_eff && (eop || !pif.enable);
      e_ack    = xf;
      if (!pif.enable) begin pos = 0; sub = 0; end
      else if (tck) begin sub = 0; pos = eop ? 0 : pos + 1; end
      else sub = sub + 1;
      if (xf) begin
        a_top = s_top; a_presc = s_presc; a_mode = s_mode; a_pol = s_pol;
        for (int i = 0; i < 4; i++) a_duty[i] = s_duty[i];
        m_pend = 0;
      end else m_pend = pend_eff;
    end
  end

  // ---------------- per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    chk("pwm_out", 32'(pif.pwm_out), 32'(e_pwm));
    chk("period_start", 32'(pif.period_start), 32'(e_ps));
    chk("load_ack", 32'(pif.load_ack), 32'(e_ack));
  end

  // ---------------- stimulus helpers
  int hi[4];
  int ps_cnt, ack_cnt, wa_hi0;

  task automatic load_cfg(input logic mode, input logic [7:0] top, input logic [7:0] presc,
                          input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                          input logic [7:0] d3, input logic [3:0] pol);
    @(negedge clk);
    pif.center_mode = mode; pif.period = top; pif.prescale = presc;
    pif.duty = {d3, d2, d1, d0}; pif.polarity = pol; pif.load = 1'b1;
    @(negedge clk);
    pif.load = 1'b0;
  endtask

  task automatic wait_ack(input string name);
    bit found;
    found = 0; wa_hi0 = 0;
    for (int k = 0; k < 600 && !found; k++) begin
      if (pif.load_ack) found = 1;
      else begin
        wa_hi0 += int'(pif.pwm_out[0]);
        @(negedge clk);
      end
    end
    chk(name, 32'(found), 32'd1);
  endtask

  task automatic sync_ps();
    bit found;
    found = 0;
    for (int k = 0; k < 600 && !found; k++) begin
      @(negedge clk);
      if (pif.period_start) found = 1;
    end
    chk("sync_period_start", 32'(found), 32'd1);
  endtask

  task automatic measure(input int n);
    sync_ps();
    for (int i = 0; i < 4; i++) hi[i] = 0;
    ps_cnt = 0; ack_cnt = 0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      for (int i = 0; i < 4; i++) hi[i] += int'(pif.pwm_out[i]);
      ps_cnt  += int'(pif.period_start);
      ack_cnt += int'(pif.load_ack);
    end
  endtask

  // ---------------- directed scenarios
  initial begin
    pif.enable = 0; pif.load = 0; pif.center_mode = 0; pif.period = 0;
    pif.prescale = 0; pif.duty = 0; pif.polarity = 0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_pwm", 32'(pif.pwm_out), 32'd0);
    chk("rst_ps", 32'(pif.period_start), 32'd0);
    chk("rst_ack", 32'(pif.load_ack), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Edge TOP=9, loaded while disabled: transfers on the next clock.
    load_cfg(0, 8'd9, 8'd0, 8'd3, 8'd5, 8'd0, 8'd12, 4'b0000);
    wait_ack("ack_while_disabled");
    @(negedge clk);
    pif.enable = 1'b1;
    measure(10);
    chk("edge_hi0", 32'(hi[0]), 32'd3);
    chk("edge_hi1", 32'(hi[1]), 32'd5);
    chk("edge_hi2_duty0", 32'(hi[2]), 32'd0);
    chk("edge_hi3_over_top", 32'(hi[3]), 32'd10);
    chk("edge_ps_per_10", 32'(ps_cnt), 32'd1);

    // Load duty0=7 captured with cnt=5: rest of period keeps duty 3.
    sync_ps();
    repeat (4) @(negedge clk);
    pif.duty[7:0] = 8'd7; pif.load = 1'b1;
    @(negedge clk);
    pif.load = 1'b0;
    wait_ack("ack_mid_period");
    chk("remainder_low", 32'(wa_hi0), 32'd0);
    measure(10);
    chk("new_duty_hi0", 32'(hi[0]), 32'd7);
    chk("no_extra_ack", 32'(ack_cnt), 32'd0);

    // Centre TOP=4.
    load_cfg(1, 8'd4, 8'd0, 8'd2, 8'd1, 8'd4, 8'd5, 4'b0000);
    wait_ack("ack_centre");
    measure(8);
    chk("ctr_hi0", 32'(hi[0]), 32'd3);
    chk("ctr_hi1", 32'(hi[1]), 32'd1);
    chk("ctr_hi2_top", 32'(hi[2]), 32'd7);
    chk("ctr_hi3_over", 32'(hi[3]), 32'd8);
    chk("ctr_ps_per_8", 32'(ps_cnt), 32'd1);
    load_cfg(1, 8'd4, 8'd0, 8'd5, 8'd1, 8'd4, 8'd5, 4'b0000);
    wait_ack("ack_centre2");
    measure(8);
    chk("ctr_const_high", 32'(hi[0]), 32'd8);

    // Prescale 2, edge TOP=3, ch1 duty 1 inverted.
    load_cfg(0, 8'd3, 8'd2, 8'd0, 8'd1, 8'd0, 8'd0, 4'b0010);
    wait_ack("ack_presc");
    measure(12);
    chk("presc_hi1_inverted", 32'(hi[1]), 32'd9);
    chk("presc_hi0", 32'(hi[0]), 32'd0);
    chk("presc_ps_per_12", 32'(ps_cnt), 32'd1);

    // Enable dropped at cnt=6, then re-enabled.
    load_cfg(0, 8'd9, 8'd0, 8'd3, 8'd5, 8'd0, 8'd12, 4'b0010);
    wait_ack("ack_before_disable");
    sync_ps();
    repeat (5) @(negedge clk);
    pif.enable = 1'b0;
    @(negedge clk);
    chk("disabled_pwm_is_pol", 32'(pif.pwm_out), 32'h2);
    chk("disabled_no_ps", 32'(pif.period_start), 32'd0);
    repeat (3) @(negedge clk);
    pif.enable = 1'b1;
    @(negedge clk);
    chk("reenable_ps", 32'(pif.period_start), 32'd1);
    chk("reenable_pwm_cnt0", 32'(pif.pwm_out), 32'h9);

    // Two loads while pending: last wins, one ack.
    sync_ps();
    load_cfg(0, 8'd9, 8'd0, 8'd1, 8'd5, 8'd0, 8'd12, 4'b0010);
    load_cfg(0, 8'd9, 8'd0, 8'd6, 8'd5, 8'd0, 8'd12, 4'b0010);
    wait_ack("ack_double_load");
    measure(10);
    chk("last_load_wins", 32'(hi[0]), 32'd6);
    chk("single_ack", 32'(ack_cnt), 32'd0);

    // Async reset mid-run with duty 0x80.
    load_cfg(0, 8'd255, 8'd0, 8'h80, 8'h80, 8'h80, 8'h80, 4'b0000);
    wait_ack("ack_before_rst");
    sync_ps();
    repeat (3) @(negedge clk);
    chk("pre_rst_high", 32'(pif.pwm_out), 32'hF);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pwm", 32'(pif.pwm_out), 32'd0);
    chk("async_rst_ps", 32'(pif.period_start), 32'd0);
    chk("async_rst_ack", 32'(pif.load_ack), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    hi[0] = 0; ack_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      hi[0] += (pif.pwm_out != 0) ? 1 : 0;
      ack_cnt += int'(pif.load_ack);
    end
    chk("post_rst_pwm_quiet", 32'(hi[0]), 32'd0);
    chk("post_rst_pending_lost", 32'(ack_cnt), 32'd0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
